mod_counter: RTL and testbench
==============================

// Module: mod_counter
// PURPOSE
//  Parametrised modulo counter, next generation of the generic slave counter.
//  Counts 0..MAX, then wraps or saturates. Adds clear, parallel load, a terminal-count
//  pulse and a sticky overflow flag. Used for I2C bit indexing (MAX=7, ACK slot on
//  tc_pulse), byte counts and timeout counting in the slave datapath.
// PARAMETERS
//  WIDTH    4         count register width; MAX must be < 2**WIDTH
//  MAX      7         terminal value; count range is 0..MAX
//  MODE     CNT_WRAP  counter_pkg::cnt_mode_e: CNT_WRAP (MAX->0) or CNT_SAT (hold at MAX)
//  RST_VAL  0         value loaded by rst and clear; must be <= MAX
// PORTS
//  FPGA_clk  in   1      system clock; all state changes on rising edge
//  rst       in   1      synchronous, active-high reset
//  clear     in   1      synchronous clear to RST_VAL; also clears ovf
//  enable    in   1      count one step this cycle
//  load      in   1      load load_val this cycle
//  load_val  in   WIDTH  parallel load value
//  count     out  WIDTH  registered count
//  at_max    out  1      combinational: count==MAX (count==0 when counting down)
//  tc_pulse  out  1      registered one-cycle pulse: terminal event occurred last edge
//  ovf       out  1      sticky: set on any terminal event; cleared by rst or clear
// BEHAVIOUR
//  - Reset: count=RST_VAL, tc_pulse=0, ovf=0. rst wins over every input.
//  - Priority at each edge: rst > clear > load > enable. Lower-priority inputs are ignored.
//  - clear: count=RST_VAL, ovf=0, tc_pulse=0.
//  - load: count=min(load_val, MAX). load_val>MAX clamps to MAX. No tc_pulse. ovf unchanged.
//  - enable, count<MAX: count+1. No terminal event.
//  - Terminal event = enable while count==MAX (load/clear/rst inactive):
//    CNT_WRAP: count->0. CNT_SAT: count stays MAX.
//    Either mode: tc_pulse=1 in the next cycle, ovf set.
//    Each enabled cycle at MAX in CNT_SAT is a new event, so held enable gives a continuous tc_pulse.
//  - tc_pulse is 0 in any cycle following a non-event edge.
//  - Arithmetic: unsigned, width WIDTH; never exceeds MAX, never relies on natural 2**WIDTH wrap.
//  - Latency: count and tc_pulse update 1 cycle after inputs are sampled; at_max has 0 latency from count.
//  - Elaboration: assertion fails if MAX>=2**WIDTH or RST_VAL>MAX.
// CONFIGURATION
//  - MOD_COUNTER_DOWN_EN defined:
//    adds input up_dn (1: up, 0: down), placed after load_val.
//    Down step: count-1. Down terminal event = enable && !up_dn && count==0:
//    CNT_WRAP: 0->MAX. CNT_SAT: hold 0. tc_pulse/ovf as for the up direction.
//    at_max reports count==0 while up_dn=0.
//  - MOD_COUNTER_DOWN_EN undefined: up_dn port absent; up-only behaviour as above.
// STRUCTURE
//  - counter_pkg: typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e.
//  - counter_pkg: I2C_BIT_MAX=7 constant, used by slave instantiations.
//  - Sub-module mod_counter_next: combinational next-count and terminal-event calculation.
//  - mod_counter: holds registers, priority logic, tc_pulse and ovf.
// TESTING (WIDTH=4, MAX=7, RST_VAL=0 unless stated)
//  1. CNT_WRAP, enable held 9 cycles from reset -> count 1..7,0,1.
//     tc_pulse high only in the cycle after count 7->0; ovf=1 from then on.
//  2. CNT_SAT, enable held 10 cycles -> count reaches 7 and stays there.
//     tc_pulse high every cycle after the first enabled edge at 7; clear -> count=0, ovf=0.
//  3. count=3, assert load=1 with load_val=12 and enable=1 -> count=7 (clamped), tc_pulse=0.
//     load_val=5 -> count=5.
//  4. count=7, assert rst, clear, load and enable together -> count=0, ovf=0, tc_pulse=0 next cycle.
//     rst mid-count at 4 -> count=0.
//  5. MOD_COUNTER_DOWN_EN, CNT_WRAP: up_dn=0, enable from 2 -> 1,0,7.
//     tc_pulse after the 0->7 edge; CNT_SAT: holds 0 with tc_pulse.
//  6. Random enable/load/clear mix over 10k cycles, checked against a reference model
//     for count, at_max, tc_pulse and ovf.

Source files
------------

// File: rtl/counter_pkg.sv
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and constants for the modulo counter family.
//               cnt_mode_e selects wrap or saturate behaviour at the
//               terminal value. I2C_BIT_MAX is the bit-index terminal
//               value used by the I2C slave instantiations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam int I2C_BIT_MAX = 7;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/mod_counter_if.sv
// ============================================================================
// Module      : mod_counter_if
// Description : Control/status bundle for mod_counter.
//               master : drives clear/enable/load/load_val (and up_dn),
//                        observes count/at_max/tc_pulse/ovf.
//               slave  : the counter side.
//               Optional macro MOD_COUNTER_DOWN_EN adds the up_dn signal
//               (1: count up, 0: count down).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mod_counter_if #(
  parameter int WIDTH = 4
);

  logic             clear;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_val;
`ifdef MOD_COUNTER_DOWN_EN
  logic             up_dn;
`endif
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             tc_pulse;
  logic             ovf;

  modport master (
    output clear, enable, load, load_val,
`ifdef MOD_COUNTER_DOWN_EN
    output up_dn,
`endif
    input  count, at_max, tc_pulse, ovf
  );

  modport slave (
    input  clear, enable, load, load_val,
`ifdef MOD_COUNTER_DOWN_EN
    input  up_dn,
`endif
    output count, at_max, tc_pulse, ovf
  );

endinterface : mod_counter_if

`default_nettype wire

// File: rtl/mod_counter_next.sv
// ============================================================================
// Module      : mod_counter_next
// Description : Combinational step calculation for mod_counter.
//               Given the current count and direction, returns the count
//               after one enabled step and whether that step is a
//               terminal event (stepping up from MAX or down from 0).
// Ports       : count_i  - current count
//               up_i     - 1: step up, 0: step down
//               next_o   - count after one enabled step
//               term_o   - this step is a terminal event
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter_next
  import counter_pkg::*;
#(
  parameter int        WIDTH = 4,
  parameter int        MAX   = 7,
  parameter cnt_mode_e MODE  = CNT_WRAP
) (
  input  wire logic [WIDTH-1:0] count_i,
  input  wire logic             up_i,
  output logic      [WIDTH-1:0] next_o,
  output logic                  term_o
);

  localparam logic [WIDTH-1:0] CMAX = WIDTH'(MAX);

  // Explicit compare against the terminal values keeps the arithmetic
  // inside 0..MAX; the natural 2**WIDTH rollover is never used.
  always_comb begin
    next_o = count_i;
    term_o = 1'b0;
    if (up_i) begin
      if (count_i == CMAX) begin
        term_o = 1'b1;
        next_o = (MODE == CNT_WRAP) ? '0 : CMAX;
      end else begin
        next_o = count_i + 1'b1;
      end
    end else begin
      if (count_i == '0) begin
        term_o = 1'b1;
        next_o = (MODE == CNT_WRAP) ? CMAX : '0;
      end else begin
        next_o = count_i - 1'b1;
      end
    end
  end

endmodule : mod_counter_next

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module      : mod_counter
// Description : Parametrised modulo counter (0..MAX) with wrap or saturate
//               mode, synchronous clear, clamped parallel load, registered
//               terminal-count pulse and sticky overflow flag.
//               Edge priority: rst > clear > load > enable.
//               Optional macro MOD_COUNTER_DOWN_EN enables down counting
//               through bus.up_dn; otherwise the counter only counts up.
// Ports       : FPGA_clk - system clock, rising edge
//               rst      - synchronous active-high reset
//               bus      - mod_counter_if.slave (clear, enable, load,
//                          load_val, [up_dn] in; count, at_max, tc_pulse,
//                          ovf out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter
  import counter_pkg::*;
#(
  parameter int        WIDTH   = 4,
  parameter int        MAX     = 7,
  parameter cnt_mode_e MODE    = CNT_WRAP,
  parameter int        RST_VAL = 0
) (
  input  wire logic    FPGA_clk,
  input  wire logic    rst,
  mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] CMAX = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] CRST = WIDTH'(RST_VAL);

  // Reject configurations whose range cannot be represented.
  if (MAX >= (2 ** WIDTH)) begin : g_bad_max
    $error("mod_counter: MAX (%0d) must be < 2**WIDTH", MAX);
  end
  if (RST_VAL > MAX) begin : g_bad_rst
    $error("mod_counter: RST_VAL (%0d) must be <= MAX", RST_VAL);
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_cnt;
  logic             step_term;
  logic             up_dir;

`ifdef MOD_COUNTER_DOWN_EN
  assign up_dir = bus.up_dn;
`else
  assign up_dir = 1'b1;
`endif

  mod_counter_next #(
    .WIDTH (WIDTH),
    .MAX   (MAX),
    .MODE  (MODE)
  ) u_next (
    .count_i (count_q),
    .up_i    (up_dir),
    .next_o  (step_cnt),
    .term_o  (step_term)
  );

  // tc_pulse defaults low so it is only high after an edge that was
  // itself a terminal event.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      count_d = CRST;
      ovf_d   = 1'b0;
    end else if (bus.load) begin
      count_d = (bus.load_val > CMAX) ? CMAX : bus.load_val;
    end else if (bus.enable) begin
      count_d = step_cnt;
      tc_d    = step_term;
      ovf_d   = ovf_q | step_term;
    end
  end

  always_ff @(posedge FPGA_clk) begin
    if (rst) begin
      count_q <= CRST;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc_pulse = tc_q;
  assign bus.ovf      = ovf_q;
  // When counting down the terminal value is 0, so at_max follows it.
  assign bus.at_max   = up_dir ? (count_q == CMAX) : (count_q == '0);

endmodule : mod_counter

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
// Module      : tb_mod_counter
// Description : Self-checking bench for mod_counter. A wrap-mode and a
//               saturate-mode instance receive identical stimulus; a
//               behavioural model pushes expected results to a scoreboard
//               queue as each input vector is applied, and entries are
//               popped and compared after the clock edge. Directed checks
//               against literal values cover the documented scenarios.
//               MOD_COUNTER_DOWN_EN adds down-count scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;
  import counter_pkg::*;

  localparam int WIDTH   = 4;
  localparam int MAX     = 7;
  localparam int RST_VAL = 0;

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    bit atm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(WIDTH)) bus_w ();
  mod_counter_if #(.WIDTH(WIDTH)) bus_s ();

  mod_counter #(.WIDTH(WIDTH), .MAX(MAX), .MODE(CNT_WRAP), .RST_VAL(RST_VAL)) u_wrap (
    .FPGA_clk (clk),
    .rst      (rst),
    .bus      (bus_w.slave)
  );

  mod_counter #(.WIDTH(WIDTH), .MAX(MAX), .MODE(CNT_SAT), .RST_VAL(RST_VAL)) u_sat (
    .FPGA_clk (clk),
    .rst      (rst),
    .bus      (bus_s.slave)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_w[$];
  exp_t sb_s[$];
  int   m_cnt[2];
  bit   m_tc[2];
  bit   m_ovf[2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: k=0 wrap, k=1 saturate.
  task automatic model_step(input int k, input bit r, input bit c, input bit l,
                            input int lv, input bit e, input bit u);
    exp_t x;
    if (r || c) begin
      m_cnt[k] = RST_VAL; m_tc[k] = 0; m_ovf[k] = 0;
    end else if (l) begin
      m_cnt[k] = (lv > MAX) ? MAX : lv; m_tc[k] = 0;
    end else if (e && u) begin
      if (m_cnt[k] == MAX) begin
        m_tc[k] = 1; m_ovf[k] = 1; m_cnt[k] = (k == 0) ? 0 : MAX;
      end else begin
        m_tc[k] = 0; m_cnt[k] = m_cnt[k] + 1;
      end
    end else if (e && !u) begin
      if (m_cnt[k] == 0) begin
        m_tc[k] = 1; m_ovf[k] = 1; m_cnt[k] = (k == 0) ? MAX : 0;
      end else begin
        m_tc[k] = 0; m_cnt[k] = m_cnt[k] - 1;
      end
    end else begin
      m_tc[k] = 0;
    end
    x.cnt = m_cnt[k];
    x.tc  = m_tc[k];
    x.ovf = m_ovf[k];
    x.atm = u ? (m_cnt[k] == MAX) : (m_cnt[k] == 0);
    if (k == 0) sb_w.push_back(x);
    else        sb_s.push_back(x);
  endtask

  // Drive one vector to both instances, push expectations, clock, compare.
  task automatic apply(input bit r, input bit c, input bit l, input int lv,
                       input bit e, input bit u);
    exp_t x;
    rst            = r;
    bus_w.clear    = c;  bus_s.clear    = c;
    bus_w.load     = l;  bus_s.load     = l;
    bus_w.load_val = WIDTH'(lv); bus_s.load_val = WIDTH'(lv);
    bus_w.enable   = e;  bus_s.enable   = e;
`ifdef MOD_COUNTER_DOWN_EN
    bus_w.up_dn = u; bus_s.up_dn = u;
`endif
    model_step(0, r, c, l, lv, e, u);
    model_step(1, r, c, l, lv, e, u);
    @(posedge clk);
    #1;
    if (sb_w.size() == 0 || sb_s.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb_w.pop_front();
      check("wrap_count", 32'(bus_w.count), 32'(x.cnt));
      check("wrap_tc",    32'(bus_w.tc_pulse), 32'(x.tc));
      check("wrap_ovf",   32'(bus_w.ovf), 32'(x.ovf));
      check("wrap_atmax", 32'(bus_w.at_max), 32'(x.atm));
      x = sb_s.pop_front();
      check("sat_count",  32'(bus_s.count), 32'(x.cnt));
      check("sat_tc",     32'(bus_s.tc_pulse), 32'(x.tc));
      check("sat_ovf",    32'(bus_s.ovf), 32'(x.ovf));
      check("sat_atmax",  32'(bus_s.at_max), 32'(x.atm));
    end
  endtask

  initial begin
    int wrap_exp[10];
    bit up;
    wrap_exp = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = RST_VAL; m_tc[k] = 0; m_ovf[k] = 0;
    end

    // Reset state
    apply(1, 0, 0, 0, 0, 1);
    check("rst_count", 32'(bus_w.count), 32'd0);
    check("rst_tc",    32'(bus_w.tc_pulse), 32'd0);
    check("rst_ovf",   32'(bus_s.ovf), 32'd0);

    // Enable held from reset: wrap counts 1..7,0,1,2; saturate holds 7
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 0, 0, 1, 1);
      check("t1_wrap_count", 32'(bus_w.count), 32'(wrap_exp[i]));
      check("t1_wrap_tc",    32'(bus_w.tc_pulse), (i == 7) ? 32'd1 : 32'd0);
      check("t1_wrap_ovf",   32'(bus_w.ovf), (i >= 7) ? 32'd1 : 32'd0);
      check("t2_sat_count",  32'(bus_s.count), (i >= 6) ? 32'd7 : 32'(i + 1));
      check("t2_sat_tc",     32'(bus_s.tc_pulse), (i >= 7) ? 32'd1 : 32'd0);
    end
    apply(0, 1, 0, 0, 1, 1);
    check("t2_clear_count", 32'(bus_s.count), 32'd0);
    check("t2_clear_ovf",   32'(bus_s.ovf), 32'd0);

    // Load clamps and outranks enable
    apply(0, 0, 1, 3, 0, 1);
    apply(0, 0, 1, 12, 1, 1);
    check("t3_clamp_count", 32'(bus_w.count), 32'd7);
    check("t3_clamp_tc",    32'(bus_w.tc_pulse), 32'd0);
    apply(0, 0, 1, 5, 0, 1);
    check("t3_load5", 32'(bus_w.count), 32'd5);

    // rst beats everything
    apply(0, 0, 1, 7, 0, 1);
    apply(0, 0, 0, 0, 1, 1);
    apply(1, 1, 1, 3, 1, 1);
    check("t4_all_count", 32'(bus_s.count), 32'd0);
    check("t4_all_ovf",   32'(bus_w.ovf), 32'd0);
    check("t4_all_tc",    32'(bus_s.tc_pulse), 32'd0);
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 1, 1);
    check("t4_mid_count", 32'(bus_w.count), 32'd4);
    apply(1, 0, 0, 0, 1, 1);
    check("t4_mid_rst", 32'(bus_w.count), 32'd0);

`ifdef MOD_COUNTER_DOWN_EN
    // Down counting from 2: wrap 1,0,7; saturate 1,0,0
    apply(0, 0, 1, 2, 0, 0);
    apply(0, 0, 0, 0, 1, 0);
    check("t5_dn1", 32'(bus_w.count), 32'd1);
    apply(0, 0, 0, 0, 1, 0);
    check("t5_dn0",    32'(bus_w.count), 32'd0);
    check("t5_atmax0", 32'(bus_w.at_max), 32'd1);
    apply(0, 0, 0, 0, 1, 0);
    check("t5_wrap7",  32'(bus_w.count), 32'd7);
    check("t5_wrapTc", 32'(bus_w.tc_pulse), 32'd1);
    check("t5_sat0",   32'(bus_s.count), 32'd0);
    check("t5_satTc",  32'(bus_s.tc_pulse), 32'd1);
`endif

    // Random mix against the model
    for (int i = 0; i < 10000; i++) begin
`ifdef MOD_COUNTER_DOWN_EN
      up = ($urandom_range(0, 1) == 1);
`else
      up = 1'b1;
`endif
      apply(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0),
            up);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mod_counter

`default_nettype wire
